// File: rtl/morse_pkg.sv
// Shared definitions for the Morse keying decoder: char codes, FSM states, timing multipliers.
package morse_pkg;

    typedef enum logic [1:0] {StIdle, StMark, StGap, StWordWait} state_e;

    localparam int unsigned DASH_U     = 2;
    localparam int unsigned CHAR_GAP_U = 2;
    localparam int unsigned WORD_GAP_U = 5;
    localparam int unsigned SAT_U      = 8;

    localparam logic [4:0] CH_A = 5'd0,  CH_B = 5'd1,  CH_C = 5'd2,  CH_D = 5'd3;
    localparam logic [4:0] CH_E = 5'd4,  CH_F = 5'd5,  CH_G = 5'd6,  CH_H = 5'd7;
    localparam logic [4:0] CH_I = 5'd8,  CH_J = 5'd9,  CH_K = 5'd10, CH_L = 5'd11;
    localparam logic [4:0] CH_M = 5'd12, CH_N = 5'd13, CH_O = 5'd14, CH_P = 5'd15;
    localparam logic [4:0] CH_Q = 5'd16, CH_R = 5'd17, CH_S = 5'd18, CH_T = 5'd19;
    localparam logic [4:0] CH_U = 5'd20, CH_V = 5'd21, CH_W = 5'd22, CH_X = 5'd23;
    localparam logic [4:0] CH_Y = 5'd24, CH_Z = 5'd25;
    localparam logic [4:0] CH_SPACE = 5'd26;
    localparam logic [4:0] CH_ERR   = 5'd31;

endpackage

// File: rtl/morse_pattern_lut.sv
// Maps an element count and dot/dash pattern (LSB = last element, 1 = dash) to a char code.
module morse_pattern_lut
    import morse_pkg::*;
(
    input  logic [2:0] nelem_i,
    input  logic [3:0] pattern_i,
    output logic [4:0] code_o
);

    always_comb begin
        code_o = CH_ERR;
        unique case ({nelem_i, pattern_i})
            {3'd1, 4'b0000}: code_o = CH_E;
            {3'd1, 4'b0001}: code_o = CH_T;
            {3'd2, 4'b0000}: code_o = CH_I;
            {3'd2, 4'b0001}: code_o = CH_A;
            {3'd2, 4'b0010}: code_o = CH_N;
            {3'd2, 4'b0011}: code_o = CH_M;
            {3'd3, 4'b0000}: code_o = CH_S;
            {3'd3, 4'b0001}: code_o = CH_U;
            {3'd3, 4'b0010}: code_o = CH_R;
            {3'd3, 4'b0011}: code_o = CH_W;
            {3'd3, 4'b0100}: code_o = CH_D;
            {3'd3, 4'b0101}: code_o = CH_K;
            {3'd3, 4'b0110}: code_o = CH_G;
            {3'd3, 4'b0111}: code_o = CH_O;
            {3'd4, 4'b0000}: code_o = CH_H;
            {3'd4, 4'b0001}: code_o = CH_V;
            {3'd4, 4'b0010}: code_o = CH_F;
            {3'd4, 4'b0100}: code_o = CH_L;
            {3'd4, 4'b0110}: code_o = CH_P;
            {3'd4, 4'b0111}: code_o = CH_J;
            {3'd4, 4'b1000}: code_o = CH_B;
            {3'd4, 4'b1001}: code_o = CH_X;
            {3'd4, 4'b1010}: code_o = CH_C;
            {3'd4, 4'b1011}: code_o = CH_Y;
            {3'd4, 4'b1100}: code_o = CH_Z;
            {3'd4, 4'b1101}: code_o = CH_Q;
            default:         code_o = CH_ERR;
        endcase
    end

endmodule

// File: rtl/morse_keying_decoder.sv
// Timing-based Morse receiver: sync + debounce the keying line, measure marks/gaps in units,
// decode chars and shift them into an 8-char display buffer.
module morse_keying_decoder
    import morse_pkg::*;
#(
    parameter int unsigned UNIT_CYCLES     = 25_000_000,
    parameter int unsigned DEBOUNCE_CYCLES = 500_000,
    parameter int unsigned MAX_ELEMENTS    = 4
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iEnable,
    input  logic        iClear,
    input  logic        iKeyed,
    output logic [4:0]  oCharCode,
    output logic        oCharValid,
    output logic        oError,
    output logic [39:0] oDisplayData,
    output logic        oMark
);

    localparam int unsigned CntW = $clog2(SAT_U * UNIT_CYCLES + 1);
    localparam int unsigned DbW  = $clog2(DEBOUNCE_CYCLES + 2);

    localparam logic [CntW-1:0] CntMax     = CntW'(SAT_U * UNIT_CYCLES);
    localparam logic [CntW-1:0] DashThr    = CntW'(DASH_U * UNIT_CYCLES);
    localparam logic [CntW-1:0] CharGapThr = CntW'(CHAR_GAP_U * UNIT_CYCLES);
    localparam logic [CntW-1:0] WordGapThr = CntW'(WORD_GAP_U * UNIT_CYCLES);
    localparam logic [39:0]     AllSpace   = {8{CH_SPACE}};

    logic [1:0]      sync_q;
    logic            keyed_s;
    logic            mark_q;
    logic [DbW-1:0]  db_cnt_q;
    logic            db_flip, rise, fall;
    logic [CntW-1:0] cnt_q;
    state_e          state_q, state_d;
    logic [3:0]      pattern_q;
    logic [2:0]      nelem_q;
    logic            ovf_q;
    logic            char_thr, word_thr;
    logic            push_elem, commit_char, commit_space, commit;
    logic [4:0]      lut_code, code_d;
    logic [4:0]      char_code_q;
    logic            char_valid_q, error_q;
    logic [39:0]     disp_q;

    always_ff @(posedge iCLK) begin
        if (iRST) sync_q <= 2'b00;
        else      sync_q <= {sync_q[0], iKeyed};
    end
    assign keyed_s = sync_q[1];

    // The new level must differ from the accepted one for DEBOUNCE_CYCLES+1 samples in a row.
    assign db_flip = (keyed_s != mark_q) && (db_cnt_q == DbW'(DEBOUNCE_CYCLES));
    assign rise    = db_flip & keyed_s;
    assign fall    = db_flip & ~keyed_s;

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            mark_q   <= 1'b0;
            db_cnt_q <= '0;
        end else if (keyed_s == mark_q) begin
            db_cnt_q <= '0;
        end else if (db_flip) begin
            mark_q   <= keyed_s;
            db_cnt_q <= '0;
        end else begin
            db_cnt_q <= db_cnt_q + DbW'(1);
        end
    end

    // Duration of the current debounced level, in cycles; 1 in the first cycle after an edge.
    always_ff @(posedge iCLK) begin
        if (iRST || !iEnable)  cnt_q <= '0;
        else if (db_flip)      cnt_q <= CntW'(1);
        else if (cnt_q != CntMax) cnt_q <= cnt_q + CntW'(1);
    end

    assign char_thr = (cnt_q == CharGapThr);
    assign word_thr = (cnt_q == WordGapThr);

    always_ff @(posedge iCLK) begin
        if (iRST) state_q <= StIdle;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:     if (rise) state_d = StMark;
            StMark:     if (fall) state_d = StGap;
            StGap: begin
                if (char_thr)  state_d = rise ? StMark : StWordWait;
                else if (rise) state_d = StMark;
            end
            StWordWait: begin
                if (word_thr)  state_d = rise ? StMark : StIdle;
                else if (rise) state_d = StMark;
            end
            default:    state_d = StIdle;
        endcase
        if (!iEnable) state_d = StIdle;
    end

    always_comb begin
        push_elem    = 1'b0;
        commit_char  = 1'b0;
        commit_space = 1'b0;
        if (iEnable) begin
            case (state_q)
                StMark:     push_elem    = fall;
                StGap:      commit_char  = char_thr;
                StWordWait: commit_space = word_thr && (char_code_q != CH_SPACE);
                default:    ;
            endcase
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRST || !iEnable || commit_char) begin
            pattern_q <= '0;
            nelem_q   <= '0;
            ovf_q     <= 1'b0;
        end else if (push_elem) begin
            pattern_q <= {pattern_q[2:0], cnt_q >= DashThr};
            if (nelem_q == 3'(MAX_ELEMENTS)) ovf_q   <= 1'b1;
            else                             nelem_q <= nelem_q + 3'd1;
        end
    end

    morse_pattern_lut u_lut (
        .nelem_i   (nelem_q),
        .pattern_i (pattern_q),
        .code_o    (lut_code)
    );

    assign commit = commit_char | commit_space;
    assign code_d = commit_space ? CH_SPACE : (ovf_q ? CH_ERR : lut_code);

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            char_code_q  <= '0;
            char_valid_q <= 1'b0;
            error_q      <= 1'b0;
            disp_q       <= AllSpace;
        end else begin
            char_valid_q <= commit;
            error_q      <= commit && (code_d == CH_ERR);
            if (commit) char_code_q <= code_d;
            if (iClear)      disp_q <= commit ? {{7{CH_SPACE}}, code_d} : AllSpace;
            else if (commit) disp_q <= {disp_q[34:0], code_d};
        end
    end

    assign oCharCode    = char_code_q;
    assign oCharValid   = char_valid_q;
    assign oError       = error_q;
    assign oDisplayData = disp_q;
    assign oMark        = mark_q;

endmodule
